key_evt_ctrl: RTL and testbench



---
 rtl/key_evt_pkg.sv | 22 ++
 rtl/key_evt_if.sv | 14 +
 rtl/key_evt_fifo.sv | 50 +++++
 rtl/key_evt_ctrl.sv | 194 +++++++++++++++++++
 tb/tb_key_evt_ctrl.sv | 286 ++++++++++++++++++++++++++++
 5 files changed

// File: rtl/key_evt_pkg.sv
// Shared event/state encodings and the event record width helper
// for the key event controller.
package key_evt_pkg;

  typedef enum logic [1:0] {
    EVT_SHORT   = 2'd0,
    EVT_LONG    = 2'd1,
    EVT_REPEAT  = 2'd2,
    EVT_RELEASE = 2'd3
  } evt_type_t;

  typedef enum logic [2:0] {
    ST_IDLE = 3'b001,
    ST_HELD = 3'b010,
    ST_LONG = 3'b100
  } key_st_t;

  function automatic int evt_w(input int kw);
    return kw + 2;
  endfunction

endpackage

// File: rtl/key_evt_if.sv
// Valid/ready event stream from the key event controller to the application.
interface key_evt_if #(
  parameter int KW = 2
) ();

  logic          evt_valid;
  logic          evt_ready;
  logic [KW-1:0] evt_key;
  logic [1:0]    evt_type;

  modport master (output evt_valid, output evt_key, output evt_type, input evt_ready);
  modport slave  (input evt_valid, input evt_key, input evt_type, output evt_ready);

endinterface

// File: rtl/key_evt_fifo.sv
// Small synchronous FIFO for queued key events; full/empty come straight
// from the pointer registers.
module key_evt_fifo #(
  parameter int WIDTH      = 4,
  parameter int FIFO_DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic [WIDTH-1:0] din,
  output logic             full,
  input  logic             pop,
  output logic [WIDTH-1:0] dout,
  output logic             empty
);

  localparam int AW = $clog2(FIFO_DEPTH);

  logic [WIDTH-1:0] mem_r [FIFO_DEPTH];
  logic [AW:0]      wr_ptr_r;
  logic [AW:0]      rd_ptr_r;
  logic             do_push_s;
  logic             do_pop_s;

  assign empty     = (wr_ptr_r == rd_ptr_r);
  assign full      = (wr_ptr_r[AW] != rd_ptr_r[AW]) && (wr_ptr_r[AW-1:0] == rd_ptr_r[AW-1:0]);
  assign do_push_s = push && !full;
  assign do_pop_s  = pop && !empty;
  assign dout      = mem_r[rd_ptr_r[AW-1:0]];

  // storage and pointer update
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr_r <= '0;
      rd_ptr_r <= '0;
      for (int i = 0; i < FIFO_DEPTH; i++) begin
        mem_r[i] <= '0;
      end
    end else begin
      if (do_push_s) begin
        mem_r[wr_ptr_r[AW-1:0]] <= din;
        wr_ptr_r                <= wr_ptr_r + 1'b1;
      end
      if (do_pop_s) begin
        rd_ptr_r <= rd_ptr_r + 1'b1;
      end
    end
  end

endmodule

// File: rtl/key_evt_ctrl.sv
// Classifies debounced key presses into SHORT/LONG/REPEAT/RELEASE events and
// round-robin queues them onto a valid/ready stream.
module key_evt_ctrl
  import key_evt_pkg::*;
#(
  parameter int NKEYS      = 4,
  parameter int TICK_DIV   = 50000,
  parameter int LONG_MS    = 1000,
  parameter int REPEAT_MS  = 200,
  parameter int FIFO_DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [NKEYS-1:0] key_state,
  key_evt_if.master        evt,
  output logic             ovf,
  input  logic             ovf_clr
);

  localparam int KW     = $clog2(NKEYS);
  localparam int EW     = evt_w(KW);
  localparam int MS_MAX = (LONG_MS > REPEAT_MS) ? LONG_MS : REPEAT_MS;
  localparam int MSW    = $clog2(MS_MAX + 1);
  localparam int PW     = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;

  logic [PW-1:0]         pre_cnt_r;
  logic                  tick_s;
  logic [NKEYS-1:0]      pend_vld_s;
  logic [NKEYS-1:0][1:0] pend_type_s;
  logic [NKEYS-1:0]      drop_s;
  logic                  gnt_vld_s;
  logic [KW-1:0]         gnt_idx_s;
  logic [KW-1:0]         rr_ptr_r;
  logic                  fifo_full_s;
  logic                  fifo_empty_s;
  logic [EW-1:0]         fifo_dout_s;

  assign tick_s = (pre_cnt_r == PW'(TICK_DIV - 1));

  // shared millisecond prescaler
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      pre_cnt_r <= '0;
    end else if (tick_s) begin
      pre_cnt_r <= '0;
    end else begin
      pre_cnt_r <= pre_cnt_r + 1'b1;
    end
  end

  for (genvar i = 0; i < NKEYS; i++) begin : g_key
    key_st_t        st_r, st_nxt_s;
    logic [MSW-1:0] ms_r, ms_nxt_s, ms_inc_s;
    logic           emit_s;
    evt_type_t      emit_type_s;
    logic           gnt_me_s;
    logic           pv_r;
    evt_type_t      pt_r;

    assign ms_inc_s       = (ms_r == {MSW{1'b1}}) ? ms_r : ms_r + 1'b1;
    assign gnt_me_s       = gnt_vld_s && (gnt_idx_s == KW'(i));
    assign pend_vld_s[i]  = pv_r;
    assign pend_type_s[i] = pt_r;
    assign drop_s[i]      = emit_s && pv_r && !gnt_me_s;

    // press classifier: release beats any threshold reached in the same cycle
    always_comb begin
      st_nxt_s    = st_r;
      ms_nxt_s    = ms_r;
      emit_s      = 1'b0;
      emit_type_s = EVT_SHORT;
      case (st_r)
        ST_IDLE: begin
          if (key_state[i]) begin
            st_nxt_s = ST_HELD;
            ms_nxt_s = '0;
          end else begin
            st_nxt_s = ST_IDLE;
          end
        end
        ST_HELD: begin
          if (!key_state[i]) begin
            emit_s      = 1'b1;
            emit_type_s = EVT_SHORT;
            st_nxt_s    = ST_IDLE;
          end else if (tick_s && (ms_inc_s == MSW'(LONG_MS))) begin
            emit_s      = 1'b1;
            emit_type_s = EVT_LONG;
            st_nxt_s    = ST_LONG;
            ms_nxt_s    = '0;
          end else if (tick_s) begin
            ms_nxt_s = ms_inc_s;
          end else begin
            ms_nxt_s = ms_r;
          end
        end
        ST_LONG: begin
          if (!key_state[i]) begin
            emit_s      = 1'b1;
            emit_type_s = EVT_RELEASE;
            st_nxt_s    = ST_IDLE;
          end else if (tick_s && (REPEAT_MS != 0) && (ms_inc_s == MSW'(REPEAT_MS))) begin
            emit_s      = 1'b1;
            emit_type_s = EVT_REPEAT;
            ms_nxt_s    = '0;
          end else if (tick_s) begin
            ms_nxt_s = ms_inc_s;
          end else begin
            ms_nxt_s = ms_r;
          end
        end
        default: begin
          st_nxt_s = ST_IDLE;
          ms_nxt_s = '0;
        end
      endcase
    end

    // key state, tick counter and one-deep pending event
    always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
        st_r <= ST_IDLE;
        ms_r <= '0;
        pv_r <= 1'b0;
        pt_r <= EVT_SHORT;
      end else begin
        st_r <= st_nxt_s;
        ms_r <= ms_nxt_s;
        if (emit_s && (!pv_r || gnt_me_s)) begin
          pv_r <= 1'b1;
          pt_r <= emit_type_s;
        end else if (gnt_me_s) begin
          pv_r <= 1'b0;
        end else begin
          pv_r <= pv_r;
        end
      end
    end
  end

  // round-robin pick starting after the last granted key; nearest candidate wins
  always_comb begin
    gnt_vld_s = 1'b0;
    gnt_idx_s = '0;
    if (!fifo_full_s) begin
      for (int j = NKEYS; j >= 1; j--) begin
        if (pend_vld_s[(int'(rr_ptr_r) + j) % NKEYS]) begin
          gnt_vld_s = 1'b1;
          gnt_idx_s = KW'((int'(rr_ptr_r) + j) % NKEYS);
        end else begin
          gnt_idx_s = gnt_idx_s;
        end
      end
    end else begin
      gnt_vld_s = 1'b0;
    end
  end

  // arbiter pointer and sticky overflow flag
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rr_ptr_r <= KW'(NKEYS - 1);
      ovf      <= 1'b0;
    end else begin
      if (gnt_vld_s) begin
        rr_ptr_r <= gnt_idx_s;
      end
      if (|drop_s) begin
        ovf <= 1'b1;
      end else if (ovf_clr) begin
        ovf <= 1'b0;
      end
    end
  end

  key_evt_fifo #(
    .WIDTH      (EW),
    .FIFO_DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (gnt_vld_s),
    .din   ({gnt_idx_s, pend_type_s[gnt_idx_s]}),
    .full  (fifo_full_s),
    .pop   (!fifo_empty_s && evt.evt_ready),
    .dout  (fifo_dout_s),
    .empty (fifo_empty_s)
  );

  assign evt.evt_valid = !fifo_empty_s;
  assign evt.evt_key   = fifo_dout_s[EW-1:2];
  assign evt.evt_type  = fifo_dout_s[1:0];

endmodule

// File: tb/tb_key_evt_ctrl.sv
// Bench for key_evt_ctrl: two instances (repeat enabled / disabled) against a
// press-duration reference model, plus directed scenarios with literal event logs.
module tb_key_evt_ctrl;
  import key_evt_pkg::*;

  localparam int N   = 4;
  localparam int TD  = 4;
  localparam int LM  = 5;
  localparam int DEP = 4;

  logic         clk       = 1'b0;
  logic         rst       = 1'b0;
  logic [N-1:0] key_state = '0;
  logic         ready     = 1'b1;
  logic         ovf_clr   = 1'b0;
  logic         ovf_a, ovf_b;

  key_evt_if #(.KW(2)) if_a ();
  key_evt_if #(.KW(2)) if_b ();
  assign if_a.evt_ready = ready;
  assign if_b.evt_ready = ready;

  key_evt_ctrl #(.NKEYS(N), .TICK_DIV(TD), .LONG_MS(LM), .REPEAT_MS(3), .FIFO_DEPTH(DEP)) dut_a (
    .clk(clk), .rst(rst), .key_state(key_state), .evt(if_a), .ovf(ovf_a), .ovf_clr(ovf_clr));
  key_evt_ctrl #(.NKEYS(N), .TICK_DIV(TD), .LONG_MS(LM), .REPEAT_MS(0), .FIFO_DEPTH(DEP)) dut_b (
    .clk(clk), .rst(rst), .key_state(key_state), .evt(if_b), .ovf(ovf_b), .ovf_clr(ovf_clr));

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // reference model: per instance, press bookkeeping by elapsed ticks
  bit         m_pr  [2][N];
  int         m_t   [2][N];
  bit         m_pv  [2][N];
  logic [1:0] m_pt  [2][N];
  int         m_ptr [2];
  logic [3:0] m_mem [2][DEP];
  int         m_hd  [2];
  int         m_cnt [2];
  bit         m_ovf [2];
  int         m_pre;

  logic [3:0] acc_a [$];
  logic [3:0] acc_b [$];
  logic [3:0] exp_q [$];

  function automatic int rep_of(int n);
    return (n == 0) ? 3 : 0;
  endfunction

  function automatic logic [3:0] ev(int k, evt_type_t t);
    return {2'(k), t};
  endfunction

  function automatic logic [4:0] dut_of(int n);
    if (n == 0) return {if_a.evt_valid, if_a.evt_key, if_a.evt_type};
    else        return {if_b.evt_valid, if_b.evt_key, if_b.evt_type};
  endfunction

  task automatic chk(string nm, logic [31:0] got, logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h expected=%0h at %0t", nm, got, exp, $time);
    end
  endtask

  task automatic ex(int k, evt_type_t t);
    exp_q.push_back(ev(k, t));
  endtask

  task automatic clear_logs();
    acc_a.delete();
    acc_b.delete();
    exp_q.delete();
  endtask

  task automatic chk_log(string nm, int n);
    logic [3:0] g [$];
    bit         ok;
    string      sg, se;
    if (n == 0) g = acc_a;
    else        g = acc_b;
    ok = (g.size() == exp_q.size());
    sg = "";
    se = "";
    foreach (g[i]) begin
      sg = {sg, $sformatf("%0h ", g[i])};
      if (ok && (g[i] !== exp_q[i])) ok = 1'b0;
    end
    foreach (exp_q[i]) se = {se, $sformatf("%0h ", exp_q[i])};
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL %s dut%0d events got [%s] expected [%s]", nm, n, sg, se);
    end
  endtask

  task automatic model_reset();
    for (int n = 0; n < 2; n++) begin
      for (int k = 0; k < N; k++) begin
        m_pr[n][k] = 1'b0; m_t[n][k] = 0; m_pv[n][k] = 1'b0; m_pt[n][k] = 2'd0;
      end
      m_ptr[n] = N - 1; m_hd[n] = 0; m_cnt[n] = 0; m_ovf[n] = 1'b0;
    end
    m_pre = 0;
  endtask

  task automatic model_step();
    bit         tk;
    bit         em [N];
    logic [1:0] et [N];
    int         g;
    bit         drp;
    if (!rst) begin
      model_reset();
    end else begin
      if (if_a.evt_valid && ready) acc_a.push_back({if_a.evt_key, if_a.evt_type});
      if (if_b.evt_valid && ready) acc_b.push_back({if_b.evt_key, if_b.evt_type});
      tk = (m_pre == TD - 1);
      for (int n = 0; n < 2; n++) begin
        for (int k = 0; k < N; k++) begin
          em[k] = 1'b0;
          et[k] = EVT_SHORT;
          if (!m_pr[n][k]) begin
            if (key_state[k]) begin m_pr[n][k] = 1'b1; m_t[n][k] = 0; end
          end else if (!key_state[k]) begin
            em[k] = 1'b1;
            et[k] = (m_t[n][k] >= LM) ? EVT_RELEASE : EVT_SHORT;
            m_pr[n][k] = 1'b0;
          end else if (tk) begin
            m_t[n][k]++;
            if (m_t[n][k] == LM) begin
              em[k] = 1'b1; et[k] = EVT_LONG;
            end else if (rep_of(n) != 0 && m_t[n][k] > LM && ((m_t[n][k] - LM) % rep_of(n)) == 0) begin
              em[k] = 1'b1; et[k] = EVT_REPEAT;
            end
          end
        end
        g = -1;
        if (m_cnt[n] < DEP) begin
          for (int j = 1; j <= N; j++) begin
            if (g < 0 && m_pv[n][(m_ptr[n] + j) % N]) g = (m_ptr[n] + j) % N;
          end
        end
        if (m_cnt[n] > 0 && ready) begin
          m_hd[n] = (m_hd[n] + 1) % DEP;
          m_cnt[n]--;
        end
        if (g >= 0) begin
          m_mem[n][(m_hd[n] + m_cnt[n]) % DEP] = {2'(g), m_pt[n][g]};
          m_cnt[n]++;
          m_pv[n][g] = 1'b0;
          m_ptr[n] = g;
        end
        drp = 1'b0;
        for (int k = 0; k < N; k++) begin
          if (em[k]) begin
            if (m_pv[n][k]) drp = 1'b1;
            else begin m_pv[n][k] = 1'b1; m_pt[n][k] = et[k]; end
          end
        end
        m_ovf[n] = drp || (m_ovf[n] && !ovf_clr);
      end
      m_pre = tk ? 0 : m_pre + 1;
    end
  endtask

  task automatic compare_all();
    logic [4:0] d;
    if (rst) begin
      for (int n = 0; n < 2; n++) begin
        d = dut_of(n);
        chk($sformatf("valid_dut%0d", n), {31'd0, d[4]}, {31'd0, (m_cnt[n] > 0)});
        if (m_cnt[n] > 0) chk($sformatf("head_dut%0d", n), {28'd0, d[3:0]}, {28'd0, m_mem[n][m_hd[n]]});
        chk($sformatf("ovf_dut%0d", n), {31'd0, (n == 0) ? ovf_a : ovf_b}, {31'd0, m_ovf[n]});
      end
    end
  endtask

  task automatic clk1();
    @(posedge clk);
    model_step();
    @(negedge clk);
    compare_all();
  endtask

  task automatic run(int n);
    repeat (n) clk1();
  endtask

  initial begin
    model_reset();
    run(3);
    chk("rst_valid_a", {31'd0, if_a.evt_valid}, 32'd0);
    chk("rst_key_a",   {30'd0, if_a.evt_key},   32'd0);
    chk("rst_type_a",  {30'd0, if_a.evt_type},  32'd0);
    chk("rst_ovf_a",   {31'd0, ovf_a},          32'd0);
    chk("rst_valid_b", {31'd0, if_b.evt_valid}, 32'd0);
    rst = 1'b1;
    run(5);

    // short press and its two-cycle latency
    clear_logs();
    key_state[0] = 1'b1; run(8); key_state[0] = 1'b0;
    clk1(); chk("short_lat1", {31'd0, if_a.evt_valid}, 32'd0);
    clk1(); chk("short_lat2", {31'd0, if_a.evt_valid}, 32'd1);
    chk("short_head", {28'd0, if_a.evt_key, if_a.evt_type}, {28'd0, ev(0, EVT_SHORT)});
    clk1(); chk("short_width", {31'd0, if_a.evt_valid}, 32'd0);
    run(3);
    ex(0, EVT_SHORT); chk_log("short_log", 0);

    // long hold with repeats on key 2
    clear_logs();
    key_state[2] = 1'b1; run(50); key_state[2] = 1'b0; run(6);
    ex(2, EVT_LONG); ex(2, EVT_REPEAT); ex(2, EVT_REPEAT); ex(2, EVT_RELEASE);
    chk_log("long_rep_log", 0);
    exp_q.delete(); ex(2, EVT_LONG); ex(2, EVT_RELEASE);
    chk_log("long_norep_log", 1);

    // long hold of key 3 with repeat disabled
    clear_logs();
    key_state[3] = 1'b1; run(85); key_state[3] = 1'b0; run(6);
    ex(3, EVT_LONG); ex(3, EVT_RELEASE);
    chk_log("rep0_log", 1);

    // round robin from pointer 3, then from pointer 1
    clear_logs();
    key_state = 4'hF; run(4); key_state = 4'h0; run(8);
    ex(0, EVT_SHORT); ex(1, EVT_SHORT); ex(2, EVT_SHORT); ex(3, EVT_SHORT);
    chk_log("rr_ptr3", 0);
    key_state[1] = 1'b1; run(4); key_state[1] = 1'b0; run(6);
    clear_logs();
    key_state = 4'hF; run(4); key_state = 4'h0; run(8);
    ex(2, EVT_SHORT); ex(3, EVT_SHORT); ex(0, EVT_SHORT); ex(1, EVT_SHORT);
    chk_log("rr_ptr1", 0);

    // backpressure, overflow and ovf clear
    clear_logs();
    ready = 1'b0;
    key_state = 4'hF; run(4); key_state = 4'h0; run(8);
    key_state[0] = 1'b1; run(4); key_state[0] = 1'b0; run(4);
    key_state[0] = 1'b1; run(4); key_state[0] = 1'b0; run(4);
    chk("bp_ovf_set", {31'd0, ovf_a}, 32'd1);
    chk("bp_valid_held", {31'd0, if_a.evt_valid}, 32'd1);
    ovf_clr = 1'b1; clk1();
    chk("bp_ovf_clr", {31'd0, ovf_a}, 32'd0);
    ovf_clr = 1'b0;
    ready = 1'b1; run(10);
    ex(2, EVT_SHORT); ex(3, EVT_SHORT); ex(0, EVT_SHORT); ex(1, EVT_SHORT); ex(0, EVT_SHORT);
    chk_log("bp_drain", 0);

    // reset while key 1 is long-held with events queued
    clear_logs();
    ready = 1'b0;
    key_state[1] = 1'b1; run(30);
    rst = 1'b0; run(2);
    chk("mid_rst_valid", {31'd0, if_a.evt_valid}, 32'd0);
    chk("mid_rst_key",   {30'd0, if_a.evt_key},   32'd0);
    chk("mid_rst_type",  {30'd0, if_a.evt_type},  32'd0);
    chk("mid_rst_ovf",   {31'd0, ovf_a},          32'd0);
    clear_logs();
    rst = 1'b1; ready = 1'b1; run(26);
    ex(1, EVT_LONG); chk_log("post_rst_long", 0);
    key_state[1] = 1'b0; run(6);
    ex(1, EVT_RELEASE); chk_log("post_rst_rel", 0);

    // randomized traffic against the model
    for (int c = 0; c < 3000; c++) begin
      for (int k = 0; k < N; k++) begin
        if ($urandom_range(0, 23) == 0) key_state[k] = ~key_state[k];
      end
      ready   = ($urandom_range(0, 3) != 0);
      ovf_clr = ($urandom_range(0, 31) == 0);
      clk1();
    end
    key_state = 4'h0; ready = 1'b1; ovf_clr = 1'b0;
    run(40);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
